// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared state encoding and default sizing for the frequency meter
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        REPORT  = 2'd2
    } fm_state_t;

    localparam int FM_CLK_HZ  = 100_000_000;
    localparam int FM_GATE_1S = 100_000_000;
    localparam int FM_CNT_W   = 27;

endpackage

// File: rtl/sync_rise_detect.sv
// sync_rise_detect: multi-flop synchronizer with a rising-edge detector and a suppressing load
module sync_rise_detect #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic sig_in,
    output logic rise
);

    logic [STAGES-1:0] sync;
    logic              s_sync;
    logic              s_prev;

    assign s_sync = sync[STAGES-1];
    assign rise   = s_sync & ~s_prev & ~load;

    // shift sig_in through the chain; s_prev tracks the synchronized level one cycle late
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync   <= '0;
            s_prev <= 1'b0;
        end else begin
            sync   <= {sync[STAGES-2:0], sig_in};
            s_prev <= s_sync;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// freq_meter: counts synchronized sig_in rising edges over a GATE_CYCLES window and reports them
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = FM_GATE_1S,
    parameter int CNT_W       = FM_CNT_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_count,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int            GW   = $clog2(GATE_CYCLES);
    localparam logic [GW-1:0] LAST = GW'(GATE_CYCLES - 1);

    fm_state_t        state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] edge_nxt;
    logic             sat;
    logic             sat_nxt;
    logic             start;
    logic             rise;

    // a window opens from IDLE or straight out of REPORT whenever en is high
    assign start = (state != MEASURE) && en;
    assign busy  = state != IDLE;

    sync_rise_detect #(.STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .load   (start),
        .sig_in (sig_in),
        .rise   (rise)
    );

    // saturating edge count including this cycle's rise
    always_comb begin
        edge_nxt = (rise && !(&edge_cnt)) ? edge_cnt + 1'b1 : edge_cnt;
        sat_nxt  = sat | (rise & (&edge_cnt));
    end

    // window sequencing; the result registers load on the last MEASURE cycle so they appear with freq_valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat        <= 1'b0;
            freq_count <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            if (start) begin
                state    <= MEASURE;
                gate_cnt <= '0;
                edge_cnt <= '0;
                sat      <= 1'b0;
            end else if (state == REPORT || !en) begin
                state <= IDLE;
            end else begin
                gate_cnt <= gate_cnt + 1'b1;
                edge_cnt <= edge_nxt;
                sat      <= sat_nxt;
                if (gate_cnt == LAST) begin
                    state      <= REPORT;
                    freq_count <= edge_nxt;
                    overflow   <= sat_nxt;
                    freq_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/freq_meter.md
# freq_meter

Gate-window frequency meter for the lab board's 100 MHz clock domain. It synchronizes an asynchronous input `sig_in`, counts its rising edges over a fixed window of `GATE_CYCLES` `clk` cycles, and reports the count with a one-cycle valid strobe. This is the measuring end of the divided-clock outputs. The default 1 s window reads Hz directly, which lets the bench and the board self-check `clk_1Hz`, `clk_2Hz`, `clk_5Hz` and `clk_500Hz`.

## Interface
- `GATE_CYCLES`, default 100_000_000: window length in `clk` cycles; must be ≥ 2.
- `CNT_W`, default 27: width of the edge count and of the reported result.
- `SYNC_STAGES`, default 2: flip-flop stages in the `sig_in` synchronizer; must be ≥ 2.
- `clk` input, 1 bit: clock.
- `rst` input, 1 bit: reset, asynchronous, active-high.
- `en` input, 1 bit: level-sensitive; high runs back-to-back measurements, low aborts or idles.
- `sig_in` input, 1 bit: signal under measurement, asynchronous to `clk`.
- `freq_count` output, CNT_W bits: rising edges counted in the last completed window; holds its value until the next report.
- `freq_valid` output, 1 bit: one-cycle strobe; `freq_count` and `overflow` update in the same cycle.
- `overflow` output, 1 bit: set when the last completed window's count saturated.
- `busy` output, 1 bit: high in MEASURE and REPORT.

## Operation
- Synchronizer: `SYNC_STAGES` flops feed `s_sync`. The edge register `s_prev` samples `s_sync`; `rise = s_sync & ~s_prev`.
- FSM states are IDLE, MEASURE and REPORT.
  - IDLE: when `en`=1, go to MEASURE. On that transition, clear `gate_cnt` and `edge_cnt`, clear `sat`, and load `s_prev` from `s_sync`. A level already high at window start is not an edge.
  - MEASURE: `gate_cnt` increments each cycle. Each `rise` increments `edge_cnt`.
    - If `edge_cnt` is all-ones, it holds and sets `sat`.
    - On the cycle with `gate_cnt == GATE_CYCLES-1`, that cycle's `rise` is counted and the FSM goes to REPORT.
    - If `en`=0 in any MEASURE cycle, go to IDLE. No report is made, and the previous outputs are unchanged.
  - REPORT: lasts exactly one cycle. Outputs `freq_count`=`edge_cnt`, `overflow`=`sat`, `freq_valid`=1. `rise` in this cycle is discarded (one dead cycle per window).
    - Next state is MEASURE if `en`=1, with the same clearing and `s_prev` load as the IDLE exit. Otherwise the next state is IDLE.
- Arithmetic: `gate_cnt` width is clog2(GATE_CYCLES) and never wraps, because it is cleared on window start. `edge_cnt` saturates and never wraps.
- `rst` while running: abort immediately and return to IDLE. No `freq_valid` is emitted for a partial window.

## Timing
- Reset values: `freq_count`=0, `freq_valid`=0, `overflow`=0, `busy`=0. State is IDLE; synchronizer, `s_prev` and counters are 0.
- Input latency: a `sig_in` rise reaches `rise` SYNC_STAGES cycles after being sampled.
- `en` rising at cycle t: MEASURE starts at t+1 and `busy`=1 from t+1.
- A window spans GATE_CYCLES MEASURE cycles. `freq_valid` pulses at t+1+GATE_CYCLES. Continuous windows repeat every GATE_CYCLES+1 cycles.
- `en` falling during REPORT: the report still completes. `busy`=0 in the next cycle.
- Maximum countable frequency: `sig_in` high and low for at least 2 `clk` cycles each (≤ 25 MHz).

## Structure
- Package `freq_meter_pkg` holds:
  - the state enum `fm_state_t` {IDLE, MEASURE, REPORT};
  - default localparams `FM_CLK_HZ`=100_000_000, `FM_GATE_1S`=100_000_000, `FM_CNT_W`=27.
- Sub-module `sync_rise_detect`: parameterized synchronizer plus rise detector. It has a `load` input that copies `s_sync` into `s_prev` and suppresses `rise` that cycle. It is reused by later button/switch input blocks.

## Test plan
All scenarios use `GATE_CYCLES`=100, `CNT_W`=8, `SYNC_STAGES`=2.
- Continuous square wave: `sig_in` period 10 cycles (5 high / 5 low), `en`=1 → each `freq_valid` is 101 cycles apart with `freq_count` ∈ {9, 10} and `overflow`=0. With phase fixed relative to the window start, the count is exactly 10 every window.
- Saturation: `sig_in` period 4 cycles, `GATE_CYCLES`=1200 → 300 rises saturate the 8-bit counter. Expect `freq_count`=255 and `overflow`=1. A following 10-cycle-period window clears `overflow` to 0.
- Abort: drop `en` at MEASURE cycle 50 → no `freq_valid` and `freq_count` unchanged. `busy`=0 the cycle after. Re-raising `en` gives a full 100-cycle window.
- Boundary: a single `sig_in` rise timed so `rise` lands on `gate_cnt`=99 → counted (`freq_count`=1). The same rise landing in the REPORT cycle → `freq_count`=0.
- Start level and reset: `sig_in` held high before `en` rises → `freq_count`=0. Assert `rst` mid-window → all outputs 0 and IDLE within the same cycle, with no spurious `freq_valid` after release.
